// File: rtl/echo_multi.sv
// echo_multi: delay-line echo effect with selectable delay and decay presets.
// y[n] = sat(x[n] + (z[n-D] >>> H)); z is either the past input (feed-forward)
// or the past output (feedback). A three-state FSM fetches the delayed sample
// from a synchronous single-port-style buffer, mixes, and writes back.
module echo_multi #(
  parameter int W      = 16,
  parameter int ADDR_W = 14,
  parameter int NUM_D  = 8,
  parameter int NUM_H  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             sample_in,
  input  logic                     in_ready,
  input  logic                     next_D,
  input  logic                     next_H,
  input  logic                     fb_mode,
  input  logic                     enable,
  output logic [W-1:0]             out,
  output logic                     out_ready,
  output logic [$clog2(NUM_D)-1:0] d_sel,
  output logic [$clog2(NUM_H)-1:0] h_sel,
  output logic                     overrun
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam int DSEL_W    = $clog2(NUM_D);
  localparam int HSEL_W    = $clog2(NUM_H);
  localparam int SEG_SHIFT = ADDR_W - DSEL_W;
  localparam int SHIFT_W   = HSEL_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    MIX
  } state_t;

  state_t state, state_next;

  logic [W-1:0]      mem [DEPTH];
  logic [W-1:0]      rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   fill;
  logic [ADDR_W:0]   d_cur;
  logic [ADDR_W:0]   d_lat;
  logic [HSEL_W-1:0] h_lat;
  logic [SHIFT_W-1:0] shift_amt;
  logic              fb_lat;
  logic              en_lat;
  logic [W-1:0]      x_reg;
  logic [W-1:0]      z_reg;
  logic              accept;
  logic              rd_en;
  logic              wr_en;
  logic [W-1:0]      zd;
  logic [W-1:0]      echo;
  logic [W:0]        sum;
  logic [W-1:0]      y;
  logic [W-1:0]      mix_out;
  logic [W-1:0]      wr_data;

  // Delay length for the current preset and the address of the delayed sample.
  // In MIX the pointer is about to advance, so the read is relative to wr_ptr+1.
  always_comb begin
    d_cur   = ((ADDR_W+1)'(d_sel) + (ADDR_W+1)'(1)) << SEG_SHIFT;
    accept  = in_ready && ((state == IDLE) || (state == MIX));
    rd_en   = accept;
    wr_en   = (state == MIX);
    rd_base = (state == MIX) ? (wr_ptr + ADDR_W'(1)) : wr_ptr;
    rd_addr = rd_base - d_cur[ADDR_W-1:0];
  end

  // Mix path: mask never-written history, attenuate, add and saturate.
  always_comb begin
    zd        = (fill < d_lat) ? '0 : z_reg;
    shift_amt = SHIFT_W'(h_lat) + SHIFT_W'(1);
    echo      = W'($signed(zd) >>> shift_amt);
    sum       = {x_reg[W-1], x_reg} + {echo[W-1], echo};
    y         = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      y = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    mix_out = en_lat ? y : x_reg;
    wr_data = (en_lat && fb_lat) ? y : x_reg;
  end

  // Next-state logic: accept in IDLE or back-to-back from MIX; READ always goes to MIX.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = in_ready ? READ : IDLE;
      READ:    state_next = MIX;
      MIX:     state_next = in_ready ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the sample and its configuration at acceptance so later preset
  // changes cannot disturb a sample already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg  <= '0;
      d_lat  <= '0;
      h_lat  <= '0;
      fb_lat <= 1'b0;
      en_lat <= 1'b0;
    end else if (accept) begin
      x_reg  <= sample_in;
      d_lat  <= d_cur;
      h_lat  <= h_sel;
      fb_lat <= fb_mode;
      en_lat <= enable;
    end
  end

  // Delay buffer: registered read, write of the mixed or dry sample in MIX.
  // The read samples the array before the same-edge write lands.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

  // Hold the returned delayed sample for the MIX cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_reg <= '0;
    end else if (state == READ) begin
      z_reg <= rd_data;
    end
  end

  // Write pointer and saturating fill count of valid history entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fill != (ADDR_W+1)'(DEPTH)) begin
        fill <= fill + (ADDR_W+1)'(1);
      end
    end
  end

  // Registered output and its one-cycle strobe, issued the cycle after MIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_ready <= 1'b0;
    end else begin
      out_ready <= (state == MIX);
      if (state == MIX) begin
        out <= mix_out;
      end
    end
  end

  // Preset selectors step once per cycle their advance input is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_sel <= '0;
      h_sel <= '0;
    end else begin
      if (next_D) begin
        d_sel <= (d_sel == DSEL_W'(NUM_D - 1)) ? '0 : d_sel + DSEL_W'(1);
      end
      if (next_H) begin
        h_sel <= (h_sel == HSEL_W'(NUM_H - 1)) ? '0 : h_sel + HSEL_W'(1);
      end
    end
  end

  // Sticky flag for a sample strobe that arrived while the buffer read was busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (in_ready && (state == READ)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_echo_multi.sv
// tb_echo_multi: scoreboard bench for echo_multi with a small buffer (DEPTH=64).
module tb_echo_multi;

  localparam int W      = 16;
  localparam int ADDR_W = 6;
  localparam int NUM_D  = 8;
  localparam int NUM_H  = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] sample_in;
  logic         in_ready;
  logic         next_D;
  logic         next_H;
  logic         fb_mode;
  logic         enable;
  logic [W-1:0] out;
  logic         out_ready;
  logic [2:0]   d_sel;
  logic [1:0]   h_sel;
  logic         overrun;

  typedef struct {
    logic [W-1:0] val;
    int           cyc;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   exp_dsel = 0;
  int   exp_hsel = 0;

  echo_multi #(
    .W(W),
    .ADDR_W(ADDR_W),
    .NUM_D(NUM_D),
    .NUM_H(NUM_H)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_in(sample_in),
    .in_ready(in_ready),
    .next_D(next_D),
    .next_H(next_H),
    .fb_mode(fb_mode),
    .enable(enable),
    .out(out),
    .out_ready(out_ready),
    .d_sel(d_sel),
    .h_sel(h_sel),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every output strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_out_ready: got out=%0d at cycle %0d, expected no output",
                 $signed(out), cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_value"}, $signed(out), $signed(mon_e.val));
        checkOutput({mon_e.name, "_latency"}, cyc - mon_e.cyc, 3);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] expv,
                               input string name, input logic nd);
    @(posedge clk);
    #1;
    sample_in = x;
    in_ready  = 1'b1;
    next_D    = nd;
    sb.push_back('{val: expv, cyc: cyc, name: name});
    if (nd) exp_dsel = (exp_dsel + 1) % NUM_D;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    next_D   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain_timeout: got %0d pending outputs, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_dsel = 0;
    exp_hsel = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic pulse_d(input int n);
    @(posedge clk);
    #1;
    next_D = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    next_D = 1'b0;
    exp_dsel = (exp_dsel + n) % NUM_D;
  endtask

  task automatic pulse_h(input int n);
    @(posedge clk);
    #1;
    next_H = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    next_H = 1'b0;
    exp_hsel = (exp_hsel + n) % NUM_H;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] xv;
    logic [W-1:0] ev;
    logic [W-1:0] bx [64];

    rst_n     = 1'b0;
    sample_in = '0;
    in_ready  = 1'b0;
    next_D    = 1'b0;
    next_H    = 1'b0;
    fb_mode   = 1'b0;
    enable    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out", $signed(out), 0);
    checkOutput("rst_out_ready", out_ready, 0);
    checkOutput("rst_d_sel", d_sel, 0);
    checkOutput("rst_h_sel", h_sel, 0);
    checkOutput("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Preset stepping and wrap
    for (int i = 1; i <= 8; i++) begin
      pulse_d(1);
      checkOutput($sformatf("d_sel_step%0d", i), d_sel, exp_dsel);
    end
    pulse_d(3);
    checkOutput("d_sel_consecutive", d_sel, 3);
    @(posedge clk);
    #1;
    next_D = 1'b1;
    next_H = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    next_D = 1'b0;
    next_H = 1'b0;
    exp_dsel = (exp_dsel + 5) % NUM_D;
    exp_hsel = (exp_hsel + 5) % NUM_H;
    checkOutput("d_sel_simul", d_sel, 0);
    checkOutput("h_sel_simul", h_sel, 1);
    pulse_h(3);
    checkOutput("h_sel_wrap", h_sel, 0);

    // Impulse, feed-forward, D=8, H=1
    do_reset();
    fb_mode = 1'b0;
    enable  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      xv = (i == 0) ? 16'd1000 : 16'd0;
      ev = (i == 0) ? 16'd1000 : (i == 8) ? 16'd500 : 16'd0;
      applyStimulus(xv, ev, $sformatf("ff_s%0d", i), 1'b0);
    end
    drain();

    // Impulse, feedback
    do_reset();
    fb_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      xv = (i == 0) ? 16'd1000 : 16'd0;
      case (i)
        0:       ev = 16'd1000;
        8:       ev = 16'd500;
        16:      ev = 16'd250;
        24:      ev = 16'd125;
        32:      ev = 16'd62;
        default: ev = 16'd0;
      endcase
      applyStimulus(xv, ev, $sformatf("fb_s%0d", i), 1'b0);
    end
    drain();

    // Positive saturation with masking of unwritten history
    do_reset();
    fb_mode = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ev = (i < 8) ? 16'd30000 : 16'h7fff;
      applyStimulus(16'd30000, ev, $sformatf("satp_s%0d", i), 1'b0);
    end
    drain();

    // Negative saturation
    do_reset();
    for (int i = 0; i < 24; i++) begin
      ev = (i < 8) ? -16'sd30000 : 16'h8000;
      applyStimulus(-16'sd30000, ev, $sformatf("satn_s%0d", i), 1'b0);
    end
    drain();

    // Selector change coinciding with acceptance uses the old delay
    do_reset();
    fb_mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      xv = (i == 0) ? 16'd1000 : 16'd0;
      ev = (i == 0) ? 16'd1000 : (i == 8 || i == 16) ? 16'd500 : 16'd0;
      applyStimulus(xv, ev, $sformatf("dchg_s%0d", i), (i == 8));
    end
    drain();
    checkOutput("d_sel_after_chg", d_sel, 1);

    // Full-depth delay across the pointer wrap
    do_reset();
    pulse_d(7);
    checkOutput("d_sel_full", d_sel, 7);
    for (int i = 0; i < 72; i++) begin
      xv = (i == 0) ? 16'd1000 : 16'd0;
      ev = (i == 0) ? 16'd1000 : (i == 64) ? 16'd500 : 16'd0;
      applyStimulus(xv, ev, $sformatf("wrap_s%0d", i), 1'b0);
    end
    drain();

    // Bypass writes the dry input even with feedback selected
    do_reset();
    pulse_d(7);
    enable  = 1'b0;
    fb_mode = 1'b1;
    for (int k = 0; k < 64; k++) begin
      bx[k] = (k % 2 == 1) ? W'(-(k + 1) * 10) : W'((k + 1) * 10);
      applyStimulus(bx[k], bx[k], $sformatf("byp_s%0d", k), 1'b0);
    end
    enable  = 1'b1;
    fb_mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ev = (k % 2 == 1) ? W'(-(k + 1) * 5) : W'((k + 1) * 5);
      applyStimulus(16'd0, ev, $sformatf("reen_s%0d", k), 1'b0);
    end
    drain();
    checkOutput("overrun_clear", overrun, 0);

    // Overrun: a strobe during READ is dropped; sample 72 echoes bypassed sample 8 (90)
    @(posedge clk);
    #1;
    sample_in = 16'd777;
    in_ready  = 1'b1;
    sb.push_back('{val: 16'd822, cyc: cyc, name: "ovr_kept"});
    @(posedge clk);
    #1;
    sample_in = 16'd5555;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    checkOutput("overrun_set", overrun, 1);
    drain();
    checkOutput("overrun_sticky", overrun, 1);
    pulse_h(2);
    checkOutput("h_sel_pre_rst", h_sel, 2);

    // Reset during MIX aborts the sample
    @(posedge clk);
    #1;
    sample_in = 16'd1234;
    in_ready  = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_dsel = 0;
    exp_hsel = 0;
    #1;
    checkOutput("midrst_out", $signed(out), 0);
    checkOutput("midrst_out_ready", out_ready, 0);
    checkOutput("midrst_d_sel", d_sel, 0);
    checkOutput("midrst_h_sel", h_sel, 0);
    checkOutput("midrst_overrun", overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midrst_pending", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
